// File: rtl/memshare_access_sched.sv
// Round-robin scheduler that shares one single-port read bank among SHARE_NUM
// requesters. It grants at most one request per cycle and issues it to the bank.
// An owner tag travels alongside each read so the returned data reaches its requester.
module memshare_access_sched #(
  parameter int SHARE_NUM  = 4,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        sched_en,
  input  logic [SHARE_NUM-1:0]        rqst_valid,
  input  logic [SHARE_NUM*ADDR_W-1:0] rqst_addr,
  output logic [SHARE_NUM-1:0]        rqst_ready,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic [SHARE_NUM-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
);

  localparam int ID_W = $clog2(SHARE_NUM);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                             state, state_nxt;
  logic [ID_W-1:0]                    rr_ptr;
  logic [ID_W-1:0]                    grant_id;
  logic [ID_W-1:0]                    issue_id;
  logic                               grant_found;
  logic                               handshake;
  logic [ADDR_W-1:0]                  grant_addr;
  logic [MEM_RD_LAT-1:0]              tag_vld;
  logic [MEM_RD_LAT-1:0][ID_W-1:0]    tag_id;

  // Anything issued but not yet returned keeps the scheduler busy.
  assign busy = mem_rd_en | (|tag_vld);

  // Round-robin search: the first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < SHARE_NUM; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(SHARE_NUM)) sum = sum - (ID_W+1)'(SHARE_NUM);
      cand = sum[ID_W-1:0];
      if (!grant_found && rqst_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Grants are allowed only while enabled and not draining; the grant is one-hot.
  always_comb begin
    handshake  = sched_en && (state != DRAIN) && grant_found;
    rqst_ready = '0;
    if (handshake) rqst_ready[grant_id] = 1'b1;
    grant_addr = '0;
    for (int i = 0; i < SHARE_NUM; i++) begin
      if (grant_id == ID_W'(i)) grant_addr = rqst_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Next-state logic: DRAIN lets in-flight reads finish before returning to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_en && (|rqst_valid)) state_nxt = GRANT;
      GRANT: begin
        if (!sched_en)                        state_nxt = busy ? DRAIN : IDLE;
        else if (!(|rqst_valid) && !busy)     state_nxt = IDLE;
      end
      DRAIN:   if (!busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Register the granted access toward the bank and advance the round-robin pointer.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      issue_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      mem_rd_en <= handshake;
      if (handshake) begin
        mem_rd_addr <= grant_addr;
        issue_id    <= grant_id;
        rr_ptr      <= (grant_id == ID_W'(SHARE_NUM-1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  // Owner tags shift in lockstep with the bank latency.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= mem_rd_en;
      tag_id[0]  <= issue_id;
      for (int k = 1; k < MEM_RD_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Capture returning data and pulse the owner's response valid for one cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_vld[MEM_RD_LAT-1]) begin
        rsp_valid[tag_id[MEM_RD_LAT-1]] <= 1'b1;
        rsp_data                        <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_memshare_access_sched.sv
// Testbench for memshare_access_sched. Three instances with bank latencies 1, 2
// and 4 share the same requester inputs, and each instance has its own bank model.
module tb_memshare_access_sched;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 16;

  logic           sys_clk = 1'b0;
  logic           rst;
  logic           sched_en;
  logic [N-1:0]   rqst_valid;
  logic [N*AW-1:0] rqst_addr;

  logic [N-1:0]   rqst_ready_l1, rqst_ready_l2, rqst_ready_l4;
  logic           mem_rd_en_l1, mem_rd_en_l2, mem_rd_en_l4;
  logic [AW-1:0]  mem_rd_addr_l1, mem_rd_addr_l2, mem_rd_addr_l4;
  logic [DW-1:0]  mem_rd_data_l1, mem_rd_data_l2, mem_rd_data_l4;
  logic [N-1:0]   rsp_valid_l1, rsp_valid_l2, rsp_valid_l4;
  logic [DW-1:0]  rsp_data_l1, rsp_data_l2, rsp_data_l4;
  logic           busy_l1, busy_l2, busy_l4;

  int n_checks = 0;
  int n_fail   = 0;

  // Round-robin model state and grant log used by the latency sweep.
  int          mptr;
  int          gsel;
  logic [3:0]  exp_ready;
  logic [3:0]  vld_r;
  logic [23:0] addr_r;
  logic [3:0]  gmask [0:63];
  logic [15:0] gdata [0:63];

  always #5 sys_clk = ~sys_clk;

  memshare_access_sched #(.SHARE_NUM(N), .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(1)) dut_l1 (
    .sys_clk(sys_clk), .rst(rst), .sched_en(sched_en), .rqst_valid(rqst_valid),
    .rqst_addr(rqst_addr), .rqst_ready(rqst_ready_l1), .mem_rd_en(mem_rd_en_l1),
    .mem_rd_addr(mem_rd_addr_l1), .mem_rd_data(mem_rd_data_l1), .rsp_valid(rsp_valid_l1),
    .rsp_data(rsp_data_l1), .busy(busy_l1));

  memshare_access_sched #(.SHARE_NUM(N), .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(2)) dut_l2 (
    .sys_clk(sys_clk), .rst(rst), .sched_en(sched_en), .rqst_valid(rqst_valid),
    .rqst_addr(rqst_addr), .rqst_ready(rqst_ready_l2), .mem_rd_en(mem_rd_en_l2),
    .mem_rd_addr(mem_rd_addr_l2), .mem_rd_data(mem_rd_data_l2), .rsp_valid(rsp_valid_l2),
    .rsp_data(rsp_data_l2), .busy(busy_l2));

  memshare_access_sched #(.SHARE_NUM(N), .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(4)) dut_l4 (
    .sys_clk(sys_clk), .rst(rst), .sched_en(sched_en), .rqst_valid(rqst_valid),
    .rqst_addr(rqst_addr), .rqst_ready(rqst_ready_l4), .mem_rd_en(mem_rd_en_l4),
    .mem_rd_addr(mem_rd_addr_l4), .mem_rd_data(mem_rd_data_l4), .rsp_valid(rsp_valid_l4),
    .rsp_data(rsp_data_l4), .busy(busy_l4));

  // Bank contents: address 0x15 holds 16'hBEEF, everything else {4'hC, addr, addr}.
  function automatic logic [15:0] mem_func(input logic [5:0] a);
    return (a == 6'h15) ? 16'hBEEF : {4'hC, a, a};
  endfunction

  // Bank models: the read issued in cycle x is valid in cycle x+LAT, otherwise 16'h0BAD.
  logic [0:0]        bv_l1 = '0;
  logic [AW-1:0]     ba_l1 = '0;
  logic [1:0]        bv_l2 = '0;
  logic [1:0][AW-1:0] ba_l2 = '0;
  logic [3:0]        bv_l4 = '0;
  logic [3:0][AW-1:0] ba_l4 = '0;

  always @(posedge sys_clk) begin
    bv_l1 <= mem_rd_en_l1;
    ba_l1 <= mem_rd_addr_l1;
    bv_l2 <= {bv_l2[0], mem_rd_en_l2};
    ba_l2 <= {ba_l2[0], mem_rd_addr_l2};
    bv_l4 <= {bv_l4[2:0], mem_rd_en_l4};
    ba_l4 <= {ba_l4[2:0], mem_rd_addr_l4};
  end

  assign mem_rd_data_l1 = bv_l1[0] ? mem_func(ba_l1)    : 16'h0BAD;
  assign mem_rd_data_l2 = bv_l2[1] ? mem_func(ba_l2[1]) : 16'h0BAD;
  assign mem_rd_data_l4 = bv_l4[3] ? mem_func(ba_l4[3]) : 16'h0BAD;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] vld, input logic [23:0] addr);
    sched_en   = en;
    rqst_valid = vld;
    rqst_addr  = addr;
  endtask

  task automatic nextCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 24'h0);
    @(negedge sys_clk);
    checkOutput("rst_ready", 32'(rqst_ready_l2), 32'h0);
    checkOutput("rst_rd_en", 32'(mem_rd_en_l2), 32'h0);
    checkOutput("rst_rd_addr", 32'(mem_rd_addr_l2), 32'h0);
    checkOutput("rst_rsp_v", 32'(rsp_valid_l2), 32'h0);
    checkOutput("rst_rsp_d", 32'(rsp_data_l2), 32'h0);
    checkOutput("rst_busy", 32'(busy_l2), 32'h0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkLat(input string tag, input int idx, input logic [3:0] act_v,
                          input logic [15:0] act_d);
    logic [3:0] ev;
    ev = (idx >= 0) ? gmask[idx] : 4'h0;
    checkOutput({tag, "_rsp_v"}, 32'(act_v), 32'(ev));
    if (ev != 4'h0) checkOutput({tag, "_rsp_d"}, 32'(act_d), 32'(gdata[idx]));
  endtask

  // T4 table: enable, valid, expected ready, response valid, response data, busy.
  logic        t4_en   [0:13] = '{1,1,1,1,0,0,1,1,1,1,1,1,1,1};
  logic [3:0]  t4_vld  [0:13] = '{4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'h0,4'h0,4'h0,4'h0,4'h0};
  logic [3:0]  t4_rdy  [0:13] = '{4'h1,4'h2,4'h4,4'h8,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0};
  logic [3:0]  t4_rspv [0:13] = '{4'h0,4'h0,4'h0,4'h0,4'h1,4'h2,4'h4,4'h8,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0};
  logic [15:0] t4_data [0:13] = '{16'h0,16'h0,16'h0,16'h0,16'hC041,16'hC082,16'hC0C3,16'hC104,
                                  16'h0,16'h0,16'h0,16'h0,16'hC041,16'h0};
  logic        t4_busy [0:13] = '{0,1,1,1,1,1,1,0,0,1,1,1,0,0};
  logic [15:0] exp_data2 [0:3] = '{16'hC041, 16'hC082, 16'hC0C3, 16'hC104};

  localparam logic [23:0] ADDR_T2 = {6'h04, 6'h03, 6'h02, 6'h01};

  initial begin
    // T1: single request from requester 2 at address 0x15.
    resetDut();
    applyStimulus(1'b1, 4'b0100, {6'h00, 6'h15, 6'h00, 6'h00});
    @(negedge sys_clk);
    checkOutput("t1_ready", 32'(rqst_ready_l2), 32'h4);
    checkOutput("t1_rd_en_t0", 32'(mem_rd_en_l2), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, {6'h00, 6'h15, 6'h00, 6'h00});
    @(negedge sys_clk);
    checkOutput("t1_rd_en_t1", 32'(mem_rd_en_l2), 32'h1);
    checkOutput("t1_rd_addr", 32'(mem_rd_addr_l2), 32'h15);
    checkOutput("t1_busy_t1", 32'(busy_l2), 32'h1);
    nextCycle();
    @(negedge sys_clk);
    checkOutput("t1_rd_en_t2", 32'(mem_rd_en_l2), 32'h0);
    checkOutput("t1_addr_hold", 32'(mem_rd_addr_l2), 32'h15);
    nextCycle();
    @(negedge sys_clk);
    checkOutput("t1_rsp_v_t3", 32'(rsp_valid_l2), 32'h0);
    checkOutput("t1_busy_t3", 32'(busy_l2), 32'h1);
    nextCycle();
    @(negedge sys_clk);
    checkOutput("t1_rsp_v_t4", 32'(rsp_valid_l2), 32'h4);
    checkOutput("t1_rsp_d_t4", 32'(rsp_data_l2), 32'hBEEF);
    checkOutput("t1_busy_t4", 32'(busy_l2), 32'h0);
    nextCycle();
    @(negedge sys_clk);
    checkOutput("t1_rsp_v_t5", 32'(rsp_valid_l2), 32'h0);
    checkOutput("t1_rsp_d_hold", 32'(rsp_data_l2), 32'hBEEF);

    // T2: all four requesting for 8 cycles from reset, responses back-to-back.
    resetDut();
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b1, (c < 8) ? 4'hF : 4'h0, ADDR_T2);
      @(negedge sys_clk);
      checkOutput("t2_ready", 32'(rqst_ready_l2), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 4 && c < 12) begin
        checkOutput("t2_rsp_v", 32'(rsp_valid_l2), 32'd1 << ((c - 4) % 4));
        checkOutput("t2_rsp_d", 32'(rsp_data_l2), 32'(exp_data2[(c - 4) % 4]));
      end else begin
        checkOutput("t2_rsp_v_idle", 32'(rsp_valid_l2), 32'd0);
      end
      nextCycle();
    end

    // T3: pointer at 1 with requesters 0 and 3 valid, grant order 3, 0, 3.
    applyStimulus(1'b1, 4'b0001, ADDR_T2);
    @(negedge sys_clk);
    checkOutput("t3_setup", 32'(rqst_ready_l2), 32'h1);
    nextCycle();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, (c < 3) ? 4'b1001 : 4'b0000, ADDR_T2);
      @(negedge sys_clk);
      checkOutput("t3_ready", 32'(rqst_ready_l2), (c == 1) ? 32'h1 : (c < 3) ? 32'h8 : 32'h0);
      nextCycle();
    end
    repeat (6) nextCycle();

    // T4: four grants, then sched_en drops; grants blocked until the drain completes.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(t4_en[c], t4_vld[c], ADDR_T2);
      @(negedge sys_clk);
      checkOutput("t4_ready", 32'(rqst_ready_l2), 32'(t4_rdy[c]));
      checkOutput("t4_rsp_v", 32'(rsp_valid_l2), 32'(t4_rspv[c]));
      if (t4_rspv[c] != 4'h0) checkOutput("t4_rsp_d", 32'(rsp_data_l2), 32'(t4_data[c]));
      checkOutput("t4_busy", 32'(busy_l2), 32'(t4_busy[c]));
      nextCycle();
    end

    // T5: reset with two accesses in flight discards them and restarts at requester 0.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 4'hF, ADDR_T2);
      @(negedge sys_clk);
      checkOutput("t5_ready", 32'(rqst_ready_l2), (c == 0) ? 32'h2 : 32'h4);
      nextCycle();
    end
    applyStimulus(1'b1, 4'h0, ADDR_T2);
    rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("t5_rst_rd_en", 32'(mem_rd_en_l2), 32'h0);
    checkOutput("t5_rst_rd_addr", 32'(mem_rd_addr_l2), 32'h0);
    checkOutput("t5_rst_rsp_v", 32'(rsp_valid_l2), 32'h0);
    checkOutput("t5_rst_rsp_d", 32'(rsp_data_l2), 32'h0);
    checkOutput("t5_rst_busy", 32'(busy_l2), 32'h0);
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      checkOutput("t5_no_rsp", 32'(rsp_valid_l2), 32'h0);
      checkOutput("t5_no_busy", 32'(busy_l2), 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 4'hF, ADDR_T2);
    @(negedge sys_clk);
    checkOutput("t5_restart", 32'(rqst_ready_l2), 32'h1);
    nextCycle();

    // T6: random traffic on all three latencies against a round-robin scoreboard.
    resetDut();
    mptr = 0;
    for (int c = 0; c < 48; c++) begin
      vld_r  = (c < 40) ? 4'($urandom_range(0, 15)) : 4'h0;
      addr_r = 24'($urandom);
      applyStimulus(1'b1, vld_r, addr_r);
      @(negedge sys_clk);
      exp_ready = 4'h0;
      gsel      = 0;
      for (int k = 0; k < 4; k++) begin
        if (exp_ready == 4'h0 && vld_r[(mptr + k) % 4]) begin
          gsel      = (mptr + k) % 4;
          exp_ready = 4'(1 << gsel);
        end
      end
      gmask[c] = exp_ready;
      gdata[c] = 16'h0;
      if (exp_ready != 4'h0) begin
        gdata[c] = mem_func(addr_r[gsel*6 +: 6]);
        mptr     = (gsel == 3) ? 0 : gsel + 1;
      end
      checkOutput("t6_ready_l1", 32'(rqst_ready_l1), 32'(exp_ready));
      checkOutput("t6_ready_l2", 32'(rqst_ready_l2), 32'(exp_ready));
      checkOutput("t6_ready_l4", 32'(rqst_ready_l4), 32'(exp_ready));
      checkLat("t6_l1", c - 3, rsp_valid_l1, rsp_data_l1);
      checkLat("t6_l2", c - 4, rsp_valid_l2, rsp_data_l2);
      checkLat("t6_l4", c - 6, rsp_valid_l4, rsp_data_l4);
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
